// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the rv32 pipeline sequencing controller.
package rv32_pipe_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2,
    FAULT = 2'd3
  } pipe_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Younger producer (MEM) wins over older (WB); x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX operand forwarding selects for both source operands.
module fwd_unit
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_RegWEn,
  input  logic [4:0] wb_rd,
  input  logic       wb_RegWEn,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB
);

  always_comb begin
    fwdA = fwd_select(ex_rs1, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
    fwdB = fwd_select(ex_rs2, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Five-stage pipeline sequencer: enables, flushes, forwarding, memory-hang
// detection and stall/flush performance counters.
module pipe_hazard_ctl
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWEn,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_RegWEn,
  input  logic             wb_RegWEn,
  input  logic             ex_pcSel,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  pipe_state_e       state_q, state_d;
  logic [BOOT_W-1:0] boot_q, boot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic              mem_stall_s;
  logic              load_use_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  fwd_unit u_fwd (
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .mem_rd     (mem_rd),
    .mem_RegWEn (mem_RegWEn),
    .wb_rd      (wb_rd),
    .wb_RegWEn  (wb_RegWEn),
    .fwdA       (fwd_a_s),
    .fwdB       (fwd_b_s)
  );

  assign mem_stall_s = mem_req & ~dmem_ack;
  assign load_use_s  = ex_is_load & ex_RegWEn & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));
  assign wait_inc_s  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    fwdA         = fwd_a_s;
    fwdB         = fwd_b_s;
    case (state_q)
      // Registers must load so the injected NOPs actually clear the pipe.
      BOOT: begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        memwb_bubble = 1'b1;
        fwdA         = FWD_RF;
        fwdB         = FWD_RF;
      end
      RUN, MWAIT: begin
        if (mem_stall_s) begin
          memwb_en     = 1'b1;
          memwb_bubble = 1'b1;
        end else if (ex_pcSel) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use_s) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      FAULT: begin
        pc_en = 1'b0;
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    stall_d = stall_q;
    flush_d = flush_q;
    case (state_q)
      BOOT: begin
        if (boot_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
          boot_d  = '0;
        end else begin
          boot_d  = boot_q + {{(BOOT_W-1){1'b0}}, 1'b1};
        end
      end
      RUN, MWAIT: begin
        if (mem_stall_s) begin
          stall_d = sat_inc(stall_q);
          wait_d  = wait_inc_s;
          if (wait_inc_s == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = MWAIT;
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
          if (ex_pcSel) begin
            flush_d = sat_inc(flush_q);
          end else if (load_use_s) begin
            stall_d = sat_inc(stall_q);
          end else begin
            stall_d = stall_q;
          end
        end
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      boot_q  <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_fault = fault_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed self-checking bench for pipe_hazard_ctl using an expected-value queue.
module tb_pipe_hazard_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_RegWEn, ex_is_load;
  logic        mem_RegWEn, wb_RegWEn, ex_pcSel, mem_req, dmem_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_fault;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [12:0] ctl;
  } exp_t;
  exp_t sb[$];

  // {pc,ifid,idex,exmem,memwb en}{ifid,idex flush, bubble}{fwdA}{fwdB}{fault}
  localparam logic [12:0] C_BOOT  = 13'b11111_111_00_00_0;
  localparam logic [12:0] C_NORM  = 13'b11111_000_00_00_0;
  localparam logic [12:0] C_LU    = 13'b00111_010_00_00_0;
  localparam logic [12:0] C_RED   = 13'b11111_110_00_00_0;
  localparam logic [12:0] C_MEM   = 13'b00001_001_00_00_0;
  localparam logic [12:0] C_FAULT = 13'b00000_000_00_00_1;

  logic [12:0] obs_ctl;
  assign obs_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, memwb_bubble, fwdA, fwdB, mem_fault};

  pipe_hazard_ctl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_is_load(ex_is_load),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_RegWEn(mem_RegWEn), .wb_RegWEn(wb_RegWEn), .ex_pcSel(ex_pcSel),
    .mem_req(mem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .fwdA(fwdA), .fwdB(fwdB), .mem_fault(mem_fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_RegWEn = 1'b0; ex_is_load = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_RegWEn = 1'b0; wb_RegWEn = 1'b0;
    ex_pcSel = 1'b0; mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Push expectation for the inputs just driven, compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [12:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(negedge clk);
    x = sb.pop_front();
    checks++;
    assert (obs_ctl === x.ctl) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs_ctl, x.ctl);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    step("rst_held_boot", C_BOOT);
    rst = 1'b0;
    step("boot_cycle1", C_BOOT);
    step("boot_cycle2", C_BOOT);
    step("run_after_boot", C_NORM);
    check_cnt("reset_stall_cnt", stall_cnt, 32'd0);
    check_cnt("reset_flush_cnt", flush_cnt, 32'd0);

    ex_is_load = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step("load_use_rs1", C_LU);
    idle_inputs();
    step("after_load_use", C_NORM);
    check_cnt("lu_stall_cnt", stall_cnt, 32'd1);

    ex_is_load = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    step("load_no_use", C_NORM);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    step("load_x0_no_hazard", C_NORM);
    idle_inputs();

    ex_is_load = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    ex_pcSel = 1'b1;
    step("redirect_over_lu", C_RED);
    idle_inputs();
    check_cnt("red_flush_cnt", flush_cnt, 32'd1);
    check_cnt("red_stall_cnt", stall_cnt, 32'd1);

    ex_is_load = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    step("load_use_rs2", C_LU);
    idle_inputs();
    check_cnt("lu2_stall_cnt", stall_cnt, 32'd2);

    mem_req = 1'b1;
    step("mwait1", C_MEM);
    ex_pcSel = 1'b1;
    step("mwait2_over_redirect", C_MEM);
    ex_pcSel = 1'b0;
    step("mwait3", C_MEM);
    step("mwait4", C_MEM);
    dmem_ack = 1'b1;
    step("mwait_ack", C_NORM);
    idle_inputs();
    dmem_ack = 1'b1;
    step("ack_without_req", C_NORM);
    idle_inputs();
    check_cnt("mwait_stall_cnt", stall_cnt, 32'd6);
    check_cnt("mwait_flush_cnt", flush_cnt, 32'd1);

    ex_rs1 = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3; mem_RegWEn = 1'b1; wb_RegWEn = 1'b1;
    step("fwd_mem_priority", C_NORM | 13'b00000_000_01_00_0);
    mem_RegWEn = 1'b0; ex_rs2 = 5'd3;
    step("fwd_wb_both", C_NORM | 13'b00000_000_10_10_0);
    mem_RegWEn = 1'b1; mem_rd = 5'd0; ex_rs1 = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd7;
    step("fwd_x0_none", C_NORM);
    wb_rd = 5'd7;
    step("fwd_b_wb", C_NORM | 13'b00000_000_00_10_0);
    idle_inputs();

    mem_req = 1'b1;
    for (int i = 0; i < 7; i++) step("near_timeout_wait", C_MEM);
    dmem_ack = 1'b1;
    step("ack_at_timeout", C_NORM);
    idle_inputs();
    step("no_fault_after_ack", C_NORM);
    check_cnt("near_to_stall_cnt", stall_cnt, 32'd13);

    mem_req = 1'b1;
    for (int i = 0; i < 8; i++) step("timeout_wait", C_MEM);
    step("fault_state", C_FAULT);
    idle_inputs();
    step("fault_sticky", C_FAULT);
    check_cnt("fault_stall_cnt", stall_cnt, 32'd21);

    mem_req = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst_from_fault", C_BOOT);
    rst = 1'b0;
    idle_inputs();
    step("reboot1", C_BOOT);
    step("reboot2", C_BOOT);
    step("rerun", C_NORM);
    check_cnt("reboot_stall_cnt", stall_cnt, 32'd0);
    check_cnt("reboot_flush_cnt", flush_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline sequencing controller for the rv32 five-stage core (IF/ID/EX/MEM/WB). It takes register-use and write-back info from the decode-side control outputs and produces the pipeline-register enables, flushes and forwarding selects. Conditions it handles:
- load-use hazards
- taken branches and jumps resolved in EX
- data-memory wait states
- post-reset pipeline clearing

It also detects a hung memory handshake and keeps stall and flush performance counters.

## Interface
Parameters:
- BOOT_CYCLES, 2, cycles of forced flush after reset
- MEM_TIMEOUT, 255, maximum wait cycles for dmem_ack before fault
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_RegWEn  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load (WBSel = memory)
- ex_rs1, ex_rs2  in  5  sources of the EX instruction, used for forwarding
- mem_rd, wb_rd  in  5  destinations in MEM / WB
- mem_RegWEn, wb_RegWEn  in  1  write enables in MEM / WB
- ex_pcSel  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage has an active data-memory access
- dmem_ack  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline register load enables
- ifid_flush, idex_flush, memwb_bubble  out  1  insert a NOP into that register on load
- fwdA, fwdB  out  2  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- mem_fault  out  1  sticky memory handshake timeout
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states:
  - BOOT: entered on rst; lasts BOOT_CYCLES cycles.
  - RUN: normal operation.
  - MWAIT: waiting on data memory.
  - FAULT: terminal; left only by rst.
- BOOT: pc_en=1, ifid_flush=idex_flush=memwb_bubble=1, fwd=00. Transition to RUN after BOOT_CYCLES cycles.
- RUN / MWAIT, evaluated in priority order:
  1. Mem stall (mem_req & ~dmem_ack): all enables 0 except memwb_en=1, memwb_bubble=1. Go to or stay in MWAIT; wait counter increments.
  2. Redirect (ex_pcSel): all enables 1, ifid_flush=idex_flush=1. This squashes any load-use dependency in ID.
  3. Load-use hazard (ex_is_load & ex_RegWEn & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))): pc_en=ifid_en=0, idex_flush=1, other enables 1.
  4. Otherwise: all enables 1, no flushes.
- MWAIT→RUN in the cycle dmem_ack=1. That cycle is evaluated with rules 2–4, and the wait counter clears.
- Wait counter reaching MEM_TIMEOUT while still stalled: mem_fault←1 and state→FAULT.
- FAULT: all enables 0, flushes 0, mem_fault=1.
- Forwarding (per operand, EX source reg s):
  - 01 if mem_RegWEn & mem_rd≠0 & mem_rd==s.
  - Else 10 if wb_RegWEn & wb_rd≠0 & wb_rd==s.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.
- stall_cnt increments in every RUN/MWAIT cycle where rule 1 or rule 3 applies.
- flush_cnt increments in every cycle where rule 2 applies.
- Both counters saturate at all-ones.

## Timing
- Enables, flushes and fwd are combinational from inputs and current state. No added latency; they are valid in the same cycle as the hazard.
- State, wait counter, mem_fault and perf counters are registered.
- Reset values: state=BOOT, boot counter=0, wait counter=0, mem_fault=0, stall_cnt=flush_cnt=0.
- Outputs while in BOOT are as listed in Operation.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 squashed instructions. A memory wait of N cycles costs N stall cycles.
- rst asserted mid-stall, or in FAULT, returns to BOOT on the next edge regardless of mem_req/dmem_ack.
- Simultaneous hazards resolve strictly by the priority order above.
- Boundary cases:
  - dmem_ack with mem_req=0 is ignored.
  - A timeout exactly at wait count MEM_TIMEOUT faults. An ack in that same cycle wins (no fault).

## Structure
- Shared package rv32_pipe_pkg holds:
  - the FSM state enum (BOOT, RUN, MWAIT, FAULT);
  - the forwarding-select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- Sub-module fwd_unit: purely combinational forwarding compare, instantiated once and producing both fwdA and fwdB. The FSM, counters and enable logic stay in pipe_hazard_ctl.

## Test plan
- Reset: rst high 3 cycles, then low → flushes=1 for exactly 2 cycles, then RUN; all counters 0, mem_fault=0.
- Load-use: ex_is_load=1, ex_RegWEn=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_en=ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt=1.
- Redirect vs load-use: same as previous plus ex_pcSel=1 → no stall, ifid_flush=idex_flush=1; flush_cnt=1, stall_cnt unchanged.
- Mem wait: mem_req=1, dmem_ack=0 for 4 cycles, then ack → 4 stall cycles with memwb_bubble=1, then RUN; stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, mem_req=1, no ack → mem_fault=1 after the 8th wait cycle and all enables 0; rst clears it.
- Forwarding: ex_rs1=3, mem_rd=3 and wb_rd=3, both writes enabled → fwdA=01; then mem_rd=0, ex_rs1=0 with wb_rd=0 → fwdA=00.
